// File: rtl/xbus_stim_pkg.sv
// X-bus stimulus generator shared types.
// Modes, FSM states and LFSR helpers.
package xbus_stim_pkg;

  typedef enum logic [1:0] {
    MODE_RAND  = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_CONST = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;

  function automatic int tag_w(int num_col);
    return $clog2(num_col) + 1;
  endfunction

  function automatic logic [31:0] lfsr_next(logic [31:0] q);
    return {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/xbus_stim_gen_lfsr.sv
// 32-bit Galois LFSR with synchronous seed load.
// One instance per X-bus channel.
module lfsr32_galois
  import xbus_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/xbus_stim_gen.sv
// X-bus stimulus generator: per-channel ifmap/filter/psum
// beats with tag sequencing, handshake and PE-domain strobe.
module xbus_stim_gen
  import xbus_stim_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter int          NUM_COL    = 4,
  parameter int          NUM_CH     = 4,
  parameter int          PE_DIV     = 4,
  parameter logic [31:0] SEED       = 32'hACE1_2024
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic                           abort,
  input  logic [1:0]                     mode,
  input  logic [7:0]                     kernel_size,
  input  logic [15:0]                    num_windows,
  input  logic [DATA_WIDTH-1:0]          const_val,
  output logic [NUM_CH*DATA_WIDTH-1:0]   ifmap_data,
  output logic [NUM_CH*DATA_WIDTH-1:0]   fltr_data,
  output logic [NUM_CH*2*DATA_WIDTH-1:0] psum_data,
  output logic [tag_w(NUM_COL)-1:0]      x_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           pe_en,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int TAG_W = tag_w(NUM_COL);
  localparam int DW    = DATA_WIDTH;

  state_e           state;
  mode_e            mode_q;
  logic [TAG_W-1:0] ks_q;
  logic [15:0]      nw_q;
  logic [15:0]      win;
  logic [DW-1:0]    cv_q;
  logic [DW-1:0]    beat;
  logic [DW-1:0]    nxt_beat;
  logic [31:0]      lfsr_q [NUM_CH];
  logic [31:0]      src [NUM_CH];
  logic [31:0]      div_cnt;
  logic [31:0]      div_nxt;
  logic             legal;
  logic             xfer;
  logic             wrap;
  logic             last;
  logic             ld;
  logic             adv;

  function automatic logic [31:0] seed_of(int c);
    logic [31:0] s;
    s = SEED ^ (32'(c) * GOLDEN);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  function automatic logic [4*DW-1:0] gen(
    int c, logic [DW-1:0] bt, logic [31:0] v
  );
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] p;
    a = '0;
    b = '0;
    p = '0;
    case (mode_q)
      MODE_RAND: begin
        a = v[DW-1:0];
        b = v[31 -: DW];
        if (a == '0) a = DW'(1);
        if (b == '0) b = DW'(1);
        p = {b, a};
      end
      MODE_RAMP: begin
        a = bt + DW'(c);
        b = bt;
      end
      MODE_CONST: begin
        a = cv_q;
        b = cv_q;
        p = {{DW{1'b0}}, cv_q};
      end
      default: ;
    endcase
    return {p, b, a};
  endfunction

  assign legal = (mode != 2'd3)
              && (kernel_size != 8'd0)
              && (32'(kernel_size) <= 32'(NUM_COL));
  assign xfer = (state == ST_RUN) && out_valid
             && out_ready && !abort;
  assign wrap = (x_tag == ks_q - 1'b1);
  assign last = wrap && (nw_q != 16'd0)
             && (win + 16'd1 == nw_q);
  assign ld  = (state == ST_LOAD) && !abort;
  assign adv = xfer && !last;
  assign nxt_beat = ld ? '0 : beat + 1'b1;

  // Beat 0 comes straight from the seed; later beats
  // from the LFSR value the step is about to produce.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      src[c] = ld ? seed_of(c) : lfsr_next(lfsr_q[c]);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    lfsr32_galois u_lfsr (
      .clk  (clk),
      .rstn (rstn),
      .load (ld),
      .seed (seed_of(c)),
      .step (xfer),
      .q    (lfsr_q[c])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifmap_data <= '0;
      fltr_data  <= '0;
      psum_data  <= '0;
      beat       <= '0;
    end else if (ld || adv) begin
      beat <= nxt_beat;
      for (int c = 0; c < NUM_CH; c++) begin
        {psum_data[c*2*DW +: 2*DW],
         fltr_data[c*DW +: DW],
         ifmap_data[c*DW +: DW]} <= gen(c, nxt_beat, src[c]);
      end
    end
  end

  assign div_nxt = (div_cnt == 32'(PE_DIV - 1))
                 ? 32'h0 : div_cnt + 32'h1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_cnt <= '0;
      pe_en   <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pe_en   <= (div_nxt == 32'(PE_DIV - 1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_RAND;
      ks_q      <= '0;
      nw_q      <= '0;
      cv_q      <= '0;
      win       <= '0;
      x_tag     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      x_tag     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && legal) begin
            mode_q  <= mode_e'(mode);
            ks_q    <= kernel_size[TAG_W-1:0];
            nw_q    <= num_windows;
            cv_q    <= const_val;
            cfg_err <= 1'b0;
            busy    <= 1'b1;
            state   <= ST_LOAD;
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        ST_LOAD: begin
          x_tag     <= '0;
          win       <= '0;
          out_valid <= 1'b1;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          if (xfer) begin
            x_tag <= wrap ? '0 : x_tag + 1'b1;
            if (wrap) win <= win + 16'd1;
            if (last) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xbus_stim_gen.sv
// Self-checking bench for xbus_stim_gen: scoreboard of
// expected beats compared on each accepted transfer.
`timescale 1ns/1ps
module tb_xbus_stim_gen;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int TW  = 3;

  typedef struct packed {
    logic [TW-1:0]       tag;
    logic [NCH*DW-1:0]   ifm;
    logic [NCH*DW-1:0]   flt;
    logic [NCH*2*DW-1:0] ps;
  } beat_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic [7:0]        kernel_size = 8'd1;
  logic [15:0]       num_windows = 16'd1;
  logic [DW-1:0]     const_val = '0;

  logic [NCH*DW-1:0]   ifmap_data;
  logic [NCH*DW-1:0]   fltr_data;
  logic [NCH*2*DW-1:0] psum_data;
  logic [TW-1:0]       x_tag;
  logic                out_valid;
  logic                pe_en;
  logic                busy;
  logic                done;
  logic                cfg_err;

  logic [15:0] ifm4;
  logic [15:0] flt4;
  logic [31:0] psum4;
  logic [TW-1:0] tag4;
  logic valid4;
  logic pe4;
  logic busy4;
  logic done4;
  logic err4;

  beat_t       sb[$];
  logic [31:0] q4[$];
  bit          use4 = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  xbus_stim_gen u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .kernel_size (kernel_size),
    .num_windows (num_windows),
    .const_val   (const_val),
    .ifmap_data  (ifmap_data),
    .fltr_data   (fltr_data),
    .psum_data   (psum_data),
    .x_tag       (x_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .pe_en       (pe_en),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  xbus_stim_gen #(.DATA_WIDTH(4)) u_dut4 (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .kernel_size (kernel_size),
    .num_windows (num_windows),
    .const_val   (const_val[3:0]),
    .ifmap_data  (ifm4),
    .fltr_data   (flt4),
    .psum_data   (psum4),
    .x_tag       (tag4),
    .out_valid   (valid4),
    .out_ready   (out_ready),
    .pe_en       (pe4),
    .busy        (busy4),
    .done        (done4),
    .cfg_err     (err4)
  );

  task automatic chk(string tag, logic [127:0] obs,
                     logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_step(logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [31:0] mdl_seed(int c);
    logic [31:0] s;
    s = 32'hACE1_2024 ^ (32'(c) * 32'h9E37_79B9);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

  task automatic push_run(int md, int ks, int nb,
                          logic [15:0] cv, bit with4);
    logic [31:0] lf [NCH];
    beat_t       e;
    logic [15:0] a;
    logic [15:0] f;
    logic [15:0] i4;
    logic [15:0] f4;
    for (int c = 0; c < NCH; c++) lf[c] = mdl_seed(c);
    for (int b = 0; b < nb; b++) begin
      e = '0;
      e.tag = TW'(b % ks);
      for (int c = 0; c < NCH; c++) begin
        if (md == 0) begin
          a = lf[c][15:0];
          f = lf[c][31:16];
          if (a == 16'h0) a = 16'h1;
          if (f == 16'h0) f = 16'h1;
          e.ps[c*32 +: 32] = {f, a};
        end else if (md == 1) begin
          a = 16'(b + c);
          f = 16'(b);
        end else begin
          a = cv;
          f = cv;
          e.ps[c*32 +: 32] = {16'h0, cv};
        end
        e.ifm[c*16 +: 16] = a;
        e.flt[c*16 +: 16] = f;
        i4[c*4 +: 4] = 4'(b + c);
        f4[c*4 +: 4] = 4'(b);
        lf[c] = mdl_step(lf[c]);
      end
      sb.push_back(e);
      if (with4) q4.push_back({i4, f4});
    end
  endtask

  task automatic drain_n(int n, int budget);
    int    got;
    beat_t e;
    got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("x_tag", x_tag, e.tag);
          chk("ifmap", ifmap_data, e.ifm);
          chk("fltr", fltr_data, e.flt);
          chk("psum", psum_data, e.ps);
          if (use4 && q4.size() > 0) begin
            chk("dw4_valid", valid4, 1);
            chk("dw4_tag", tag4, e.tag);
            chk("dw4_data", {ifm4, flt4}, q4.pop_front());
            chk("dw4_psum", psum4, 0);
          end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    chk("beats_before_timeout", got, n);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pe_seen;
    logic [NCH*DW-1:0]   s_i;
    logic [NCH*DW-1:0]   s_f;
    logic [NCH*2*DW-1:0] s_p;
    logic [TW-1:0]       s_t;

    // reset state
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_tag", x_tag, 0);
    chk("rst_ifmap", ifmap_data, 0);
    chk("rst_fltr", fltr_data, 0);
    chk("rst_psum", psum_data, 0);
    chk("rst_pe_en", pe_en, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      pe_seen[i] = pe_en;
      chk("pe_en_dw4", pe4, pe_en);
    end
    chk("pe_en_pattern", pe_seen, 16'h4444);

    // ramp run, 3 tags x 2 windows
    mode = 2'd1; kernel_size = 8'd3; num_windows = 16'd2;
    out_ready = 1'b1;
    push_run(1, 3, 6, 16'h0, 1'b0);
    pulse_start();
    chk("lat_load_valid", out_valid, 0);
    chk("lat_load_busy", busy, 1);
    @(posedge clk); #1;
    chk("lat_run_valid", out_valid, 1);
    drain_n(6, 20);
    chk("ramp_done", done, 1);
    chk("ramp_done_valid", out_valid, 0);
    chk("ramp_hold_ch2", ifmap_data[47:32], 16'd7);
    @(posedge clk); #1;
    chk("ramp_done_pulse", done, 0);
    chk("ramp_idle_busy", busy, 0);

    // random with a 5-cycle stall
    mode = 2'd0; kernel_size = 8'd4; num_windows = 16'd3;
    push_run(0, 4, 12, 16'h0, 1'b0);
    pulse_start();
    @(posedge clk); #1;
    drain_n(5, 20);
    out_ready = 1'b0;
    s_i = ifmap_data; s_f = fltr_data;
    s_p = psum_data; s_t = x_tag;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_ifmap", ifmap_data, s_i);
      chk("stall_fltr", fltr_data, s_f);
      chk("stall_psum", psum_data, s_p);
      chk("stall_tag", x_tag, s_t);
      chk("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    drain_n(7, 30);
    chk("rand_done", done, 1);
    @(posedge clk); #1;

    // illegal configs
    mode = 2'd1; kernel_size = 8'd0;
    pulse_start();
    chk("ks0_cfg_err", cfg_err, 1);
    chk("ks0_busy", busy, 0);
    chk("ks0_dw4_err", err4, 1);
    @(posedge clk); #1;
    chk("ks0_valid", out_valid, 0);
    kernel_size = 8'd5;
    pulse_start();
    chk("ks5_cfg_err", cfg_err, 1);
    chk("ks5_busy", busy, 0);
    kernel_size = 8'd2; num_windows = 16'd1;
    push_run(1, 2, 2, 16'h0, 1'b0);
    pulse_start();
    chk("legal_clears_err", cfg_err, 0);
    chk("legal_busy", busy, 1);
    @(posedge clk); #1;
    drain_n(2, 10);
    chk("legal_done", done, 1);
    @(posedge clk); #1;
    mode = 2'd3;
    pulse_start();
    chk("mode3_cfg_err", cfg_err, 1);
    chk("mode3_busy", busy, 0);

    // constant mode, endless run, aborted
    mode = 2'd2; kernel_size = 8'd4; num_windows = 16'd0;
    const_val = 16'h00A5;
    push_run(2, 4, 10, 16'h00A5, 1'b0);
    pulse_start();
    chk("const_clears_err", cfg_err, 0);
    @(posedge clk); #1;
    drain_n(10, 20);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_tag", x_tag, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    chk("abort_done_late", done, 0);
    chk("abort_stays_idle", busy, 0);

    // 4-bit ramp wrap, start ignored mid-run
    mode = 2'd1; kernel_size = 8'd4; num_windows = 16'd5;
    push_run(1, 4, 20, 16'h0, 1'b1);
    use4 = 1'b1;
    pulse_start();
    @(posedge clk); #1;
    drain_n(8, 20);
    start = 1'b1; mode = 2'd2; kernel_size = 8'd1;
    drain_n(1, 5);
    start = 1'b0;
    chk("midrun_busy", busy, 1);
    drain_n(11, 20);
    use4 = 1'b0;
    chk("wrap_done", done, 1);
    chk("wrap_done_dw4", done4, 1);
    chk("wrap_busy_dw4", busy4, 0);
    @(posedge clk); #1;

    // asynchronous reset mid-run
    mode = 2'd1; kernel_size = 8'd4; num_windows = 16'd0;
    pulse_start();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_valid", out_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tag", x_tag, 0);
    chk("arst_ifmap", ifmap_data, 0);
    chk("arst_pe_en", pe_en, 0);
    #1 rstn = 1'b1;
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xbus_stim_gen.md
Name: xbus_stim_gen

Overview:
- Synthesizable, parametrised X-bus stimulus generator for the PE array.
- Drives NUM_CH independent channels of ifmap/filter/psum data plus an X_TAG sequence that cycles over the kernel width.
- Supports random (LFSR), ramp and constant data modes, a valid/ready handshake with stall, a bounded window count, and a PE-domain clock-enable strobe in place of a generated second clock.
- Sits between the testbench/host sequencer and the XBUS controllers; reusable on FPGA for self-test.

Parameters:
- DATA_WIDTH, 16, ifmap/filter word width; legal range 4..16; psum width is 2*DATA_WIDTH.
- NUM_COL, 4, PE columns; sets the tag range; TAG_W = $clog2(NUM_COL)+1.
- NUM_CH, 4, number of parallel X-bus channels (one per PE row).
- PE_DIV, 4, clk cycles per PE-domain beat; legal range >= 1.
- SEED, 32'hACE1_2024, base LFSR seed.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous reset, active-low
- start  in  1  pulse; begins a run when IDLE and the config is legal
- abort  in  1  synchronous abort to IDLE
- mode  in  2  0 = LFSR random, 1 = ramp, 2 = constant, 3 = reserved (treated as illegal)
- kernel_size  in  8  tags per window; legal 1..NUM_COL
- num_windows  in  16  windows per run; 0 = run until abort
- const_val  in  DATA_WIDTH  data used in constant mode
- ifmap_data  out  NUM_CH*DATA_WIDTH  packed, channel 0 in the LSBs
- fltr_data  out  NUM_CH*DATA_WIDTH  packed
- psum_data  out  NUM_CH*2*DATA_WIDTH  packed
- x_tag  out  TAG_W  current tag, shared by all channels
- out_valid  out  1  beat valid
- out_ready  in  1  consumer accepts the beat
- pe_en  out  1  one-cycle strobe every PE_DIV clk cycles
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse at the end of a run
- cfg_err  out  1  sticky; set by a start with an illegal config, cleared by the next legal start

Behaviour:
- Reset values: all data outputs 0, x_tag 0, out_valid 0, busy 0, done 0, cfg_err 0, pe_en 0, divider count 0, FSM in IDLE.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE -> LOAD on start with a legal config. Config (mode, kernel_size, num_windows, const_val) is latched at this point; later input changes have no effect mid-run.
- Illegal start: kernel_size 0 or > NUM_COL, or mode 3. Sets cfg_err and the FSM stays in IDLE.
- start is ignored while busy.
- LOAD (1 cycle): seed channel c's LFSR to SEED ^ (c*32'h9E37_79B9), forced to 1 if the result is 0. Clear tag, window and beat counters. -> RUN.
- out_valid rises exactly 2 cycles after start is sampled.
- RUN: out_valid = 1. A transfer occurs when out_valid && out_ready.
  - While stalled, all outputs hold stable.
  - On each transfer: advance every LFSR one step, increment the beat count, and advance the tag.
  - x_tag counts 0..kernel_size-1, then wraps to 0 and increments the window count.
  - When the window count reaches num_windows (nonzero) on a wrap -> DONE.
- DONE (1 cycle): done = 1, out_valid = 0 -> IDLE. Data outputs hold their last values.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h8020_0003.
- Random mode, per channel c:
  - ifmap = lfsr[DATA_WIDTH-1:0]
  - fltr = lfsr[31 -: DATA_WIDTH]
  - psum = {fltr, ifmap}
  - an ifmap or fltr value of 0 is replaced by 1 (minimum 1).
- Ramp mode: ifmap = (beat + c) mod 2^DATA_WIDTH, fltr = beat mod 2^DATA_WIDTH, psum = 0. All wrap silently.
- Constant mode: ifmap = fltr = const_val, psum = {DATA_WIDTH'b0, const_val}.
- Output data is registered and presents the beat-0 value on the first valid cycle.
- pe_en: free-running divider, high when count == PE_DIV-1; unaffected by the FSM or abort. PE_DIV = 1 gives pe_en constantly high after reset.
- abort: in any state, next cycle -> IDLE with out_valid 0, busy 0, x_tag 0, and no done pulse. abort beats start in the same cycle.
- Transfer on the last beat together with abort: abort wins; no done.
- Asynchronous reset mid-run returns everything to reset values immediately.

Decomposition:
- Package xbus_stim_pkg: the mode enum (MODE_RAND, MODE_RAMP, MODE_CONST), the FSM state enum, LFSR_POLY, GOLDEN constant 32'h9E37_79B9, and a TAG_W helper function.
- Sub-module lfsr32_galois (clk, rstn, load, seed, step, q), instantiated NUM_CH times in a generate loop.

Test Plan:
- Reset check: hold rstn low, then release -> all outputs 0, pe_en pulses every 4th cycle.
- Ramp run, kernel_size = 3, num_windows = 2, out_ready = 1 -> 6 beats:
  - x_tag sequence 0,1,2,0,1,2
  - channel 2 ifmap sequence 2..7
  - done pulses 1 cycle after the last beat; out_valid first seen 2 cycles after start.
- Random mode, stall: drop out_ready for 5 cycles mid-run -> data and x_tag hold; the resumed sequence matches a software LFSR model (seed SEED^0 for ch0) with no skipped values; no zero data.
- Illegal config: kernel_size = 0, then kernel_size = 5 with NUM_COL = 4 -> cfg_err = 1, busy stays 0. A following legal start clears cfg_err.
- Abort: num_windows = 0, constant mode const_val = 16'h00A5, abort after 10 beats -> every beat ifmap = fltr = 00A5 and psum = 0000_00A5; idle next cycle; no done pulse.
- Ramp wrap, DATA_WIDTH = 4: 20 beats -> fltr wraps 15 -> 0; a start issued mid-run is ignored.
